// File: rtl/jtcps1_gfx_range_mapper_if.sv
// Lookup request/response bundle between the tile/object fetchers and the GFX range mapper.
interface jtcps1_gfx_range_mapper_if #(
    parameter int unsigned CODEW = 16,
    parameter int unsigned BANKW = 4,
    parameter int unsigned IDXW  = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       layer;
    logic [CODEW-1:0] code;
    logic             out_valid;
    logic [BANKW-1:0] offset;
    logic [BANKW-1:0] mask;
    logic             unmapped;
    logic [IDXW-1:0]  hit_idx;

    modport master (
        output req_valid, layer, code,
        input  req_ready, out_valid, offset, mask, unmapped, hit_idx
    );

    modport slave (
        input  req_valid, layer, code,
        output req_ready, out_valid, offset, mask, unmapped, hit_idx
    );
endinterface

// File: rtl/jtcps1_gfx_range_mapper.sv
// Run-time loadable code-range table mapping (layer, tile code) to a GFX ROM bank offset/mask.
// Lookups resolve over two registered edges after the accept edge; results are one-cycle strobes.
module jtcps1_gfx_range_mapper #(
    parameter  int unsigned NRANGES = 16,
    parameter  int unsigned NBANKS  = 4,
    parameter  int unsigned CODEW   = 16,
    parameter  int unsigned BANKW   = 4,
    localparam int unsigned IDXW    = $clog2(NRANGES),
    localparam int unsigned BSELW   = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cfg_we_i,
    input  logic [IDXW-1:0]         cfg_idx_i,
    input  logic                    cfg_en_i,
    input  logic [4:0]              cfg_layers_i,
    input  logic [CODEW-1:0]        cfg_start_i,
    input  logic [CODEW-1:0]        cfg_end_i,
    input  logic [BSELW-1:0]        cfg_bank_i,
    input  logic                    cfg_clr_i,
    output logic                    busy_o,
    input  logic [NBANKS*BANKW-1:0] bank_offset_i,
    input  logic [NBANKS*BANKW-1:0] bank_mask_i,
    jtcps1_gfx_range_mapper_if.slave lk
);
    localparam logic [IDXW-1:0] LastIdx = IDXW'(NRANGES - 1);

    typedef enum logic {StClear, StRun} state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] cnt_q, cnt_d;

    logic             en_q    [NRANGES];
    logic [4:0]       lyr_q   [NRANGES];
    logic [CODEW-1:0] start_q [NRANGES];
    logic [CODEW-1:0] end_q   [NRANGES];
    logic [BSELW-1:0] bank_q  [NRANGES];

    logic               accept;
    logic [7:0]         lyr_oh;
    logic [NRANGES-1:0] m;

    logic               s1_valid_q;
    logic [NRANGES-1:0] s1_m_q;
    logic               pe_hit;
    logic [IDXW-1:0]    pe_idx;
    logic               s2_valid_q, s2_hit_q;
    logic [IDXW-1:0]    s2_idx_q;
    logic               s3_valid_q, s3_live_q, s3_hit_q;
    logic [IDXW-1:0]    s3_idx_q;
    logic [BSELW-1:0]   s3_bank_q;
    logic               bank_ok;
    logic [BANKW-1:0]   sel_off, sel_msk;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StClear: begin
                if (cfg_clr_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LastIdx) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (cfg_clr_i) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o       = (state_q == StClear);
    assign lk.req_ready = (state_q == StRun);
    assign accept       = lk.req_valid & lk.req_ready;

    // Writes only land in RUN and lose to a coincident clear request.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (state_q == StClear) begin
                en_q[cnt_q] <= 1'b0;
            end else if (cfg_we_i && !cfg_clr_i) begin
                en_q[cfg_idx_i]    <= cfg_en_i;
                lyr_q[cfg_idx_i]   <= cfg_layers_i;
                start_q[cfg_idx_i] <= cfg_start_i;
                end_q[cfg_idx_i]   <= cfg_end_i;
                bank_q[cfg_idx_i]  <= cfg_bank_i;
            end
        end
    end

    // Layers 5..7 shift out of the low five bits and so never match.
    assign lyr_oh = 8'd1 << lk.layer;

    always_comb begin
        m = '0;
        for (int i = 0; i < NRANGES; i++) begin
            m[i] = en_q[i] & (|(lyr_q[i] & lyr_oh[4:0])) &
                   (lk.code >= start_q[i]) & (lk.code <= end_q[i]);
        end
    end

    always_comb begin
        pe_hit = 1'b0;
        pe_idx = '0;
        for (int i = NRANGES - 1; i >= 0; i--) begin
            if (s1_m_q[i]) begin
                pe_hit = 1'b1;
                pe_idx = i[IDXW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_m_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_hit_q   <= 1'b0;
            s2_idx_q   <= '0;
            s3_valid_q <= 1'b0;
            s3_live_q  <= 1'b0;
            s3_hit_q   <= 1'b0;
            s3_idx_q   <= '0;
            s3_bank_q  <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) s1_m_q <= m;
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_hit_q <= pe_hit;
                s2_idx_q <= pe_idx;
            end
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_live_q <= 1'b1;
                s3_hit_q  <= s2_hit_q;
                s3_idx_q  <= s2_idx_q;
                s3_bank_q <= bank_q[s2_idx_q];
            end
        end
    end

    if (NBANKS < (1 << BSELW)) begin : g_bank_chk
        assign bank_ok = (s3_bank_q < BSELW'(NBANKS));
    end else begin : g_bank_full
        assign bank_ok = 1'b1;
    end

    always_comb begin
        sel_off = '0;
        sel_msk = '0;
        for (int b = 0; b < NBANKS; b++) begin
            if (s3_bank_q == b[BSELW-1:0]) begin
                sel_off = bank_offset_i[b*BANKW +: BANKW];
                sel_msk = bank_mask_i[b*BANKW +: BANKW];
            end
        end
    end

    // Before the first completed lookup the outputs show the reset values.
    always_comb begin
        lk.out_valid = s3_valid_q;
        lk.offset    = '0;
        lk.mask      = '0;
        lk.unmapped  = 1'b1;
        lk.hit_idx   = '0;
        if (s3_live_q) begin
            if (s3_hit_q && bank_ok) begin
                lk.offset   = sel_off;
                lk.mask     = sel_msk;
                lk.unmapped = 1'b0;
                lk.hit_idx  = s3_idx_q;
            end else begin
                lk.mask = '1;
            end
        end
    end
endmodule

// File: tb/tb_jtcps1_gfx_range_mapper.sv
// Directed bench for the GFX range mapper; results packed as hex nibbles {valid,unmapped,off,mask,idx}.
module tb_jtcps1_gfx_range_mapper;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we, cfg_en, cfg_clr, busy;
    logic [3:0]  cfg_idx;
    logic [4:0]  cfg_layers;
    logic [15:0] cfg_start, cfg_end;
    logic [1:0]  cfg_bank;
    logic [15:0] bank_offset, bank_mask;
    int          nvec = 0;
    int          nbad = 0;

    jtcps1_gfx_range_mapper_if #(.CODEW(16), .BANKW(4), .IDXW(4)) bus ();

    jtcps1_gfx_range_mapper #(
        .NRANGES(16), .NBANKS(4), .CODEW(16), .BANKW(4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_we_i     (cfg_we),
        .cfg_idx_i    (cfg_idx),
        .cfg_en_i     (cfg_en),
        .cfg_layers_i (cfg_layers),
        .cfg_start_i  (cfg_start),
        .cfg_end_i    (cfg_end),
        .cfg_bank_i   (cfg_bank),
        .cfg_clr_i    (cfg_clr),
        .busy_o       (busy),
        .bank_offset_i(bank_offset),
        .bank_mask_i  (bank_mask),
        .lk           (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] res();
        return {12'h0, 3'b0, bus.out_valid, 3'b0, bus.unmapped, bus.offset, bus.mask,
                bus.hit_idx};
    endfunction

    task automatic set_entry(input logic [3:0] idx, input logic en, input logic [4:0] lyr,
                             input logic [15:0] st, input logic [15:0] en_code,
                             input logic [1:0] bank);
        cfg_we     = 1'b1;
        cfg_idx    = idx;
        cfg_en     = en;
        cfg_layers = lyr;
        cfg_start  = st;
        cfg_end    = en_code;
        cfg_bank   = bank;
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic en, input logic [4:0] lyr,
                             input logic [15:0] st, input logic [15:0] en_code,
                             input logic [1:0] bank);
        set_entry(idx, en, lyr, st, en_code, bank);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic req(input logic [2:0] ly, input logic [15:0] cd);
        bus.req_valid = 1'b1;
        bus.layer     = ly;
        bus.code      = cd;
    endtask

    task automatic lookup(input string tag, input logic [2:0] ly, input logic [15:0] cd,
                          input logic [31:0] exp);
        req(ly, cd);
        chk({tag, "_rdy"}, bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk({tag, "_lat"}, bus.out_valid, 0);
        tick();
        chk(tag, res(), exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int guard;
        logic seen;

        rst_n = 1'b0; cfg_we = 1'b0; cfg_clr = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
        cfg_layers = '0; cfg_start = '0; cfg_end = '0; cfg_bank = '0;
        bank_offset = 16'h0430; bank_mask = 16'h0F70;
        bus.req_valid = 1'b0; bus.layer = '0; bus.code = '0;
        repeat (3) tick();
        chk("rst_out", res(), 'h01000);
        chk("rst_busy", busy, 1);
        chk("rst_rdy", bus.req_ready, 0);

        // Release reset with a request pending; it must not be taken while busy.
        rst_n = 1'b1;
        req(1, 16'h1234);
        n = busy ? 1 : 0;
        seen = 1'b0;
        guard = 0;
        while (busy && guard < 40) begin
            if (bus.req_ready || bus.out_valid) seen = 1'b1;
            tick();
            guard++;
            if (busy) n++;
        end
        bus.req_valid = 1'b0;
        chk("init_busy_len", n, 16);
        repeat (3) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        chk("init_no_accept", seen, 0);

        cfg_write(0, 1, 5'b00010, 16'h0000, 16'h1FFF, 1);
        lookup("scr1_hit", 1, 16'h1234, 'h10370);

        // Three back-to-back misses: wrong layer, past range end, invalid layer.
        for (int t = 0; t < 6; t++) begin
            if (t == 0) req(0, 16'h1234);
            else if (t == 1) req(1, 16'h2000);
            else if (t == 2) req(6, 16'h1234);
            else bus.req_valid = 1'b0;
            tick();
            if (t >= 2 && t <= 4) chk($sformatf("b2b_%0d", t - 2), res(), 'h110F0);
            else chk($sformatf("b2b_idle_%0d", t), bus.out_valid, 0);
        end

        bank_offset = 16'hA430;
        bank_mask   = 16'hBF70;
        cfg_write(2, 1, 5'h1F, 16'h0000, 16'hFFFF, 3);
        cfg_write(5, 1, 5'h1F, 16'h1000, 16'h10FF, 0);
        lookup("prio_scr2", 2, 16'h1080, 'h10AB2);
        lookup("prio_stars", 4, 16'h1080, 'h10AB2);
        lookup("end_incl", 1, 16'h1FFF, 'h10370);
        lookup("past_end", 1, 16'h2000, 'h10AB2);

        // Rewrite entry 0 on the same edge a lookup is accepted.
        set_entry(0, 1, 5'b00010, 16'h0000, 16'h0FFF, 1);
        req(1, 16'h1234);
        tick();
        cfg_we = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("we_old", res(), 'h10370);
        tick();
        chk("we_new", res(), 'h10AB2);

        // Clear with two lookups in flight; a write mid-clear must be dropped.
        req(1, 16'h0800);
        tick();
        req(2, 16'h1080);
        tick();
        bus.req_valid = 1'b0;
        cfg_clr = 1'b1;
        tick();
        chk("clr_r1", res(), 'h10370);
        cfg_clr = 1'b0;
        n = busy ? 1 : 0;
        tick();
        chk("clr_r2", res(), 'h10AB2);
        if (busy) n++;
        guard = 0;
        while (busy && guard < 40) begin
            if (n == 10) set_entry(1, 1, 5'h1F, 16'h0000, 16'hFFFF, 1);
            else cfg_we = 1'b0;
            tick();
            guard++;
            if (busy) n++;
        end
        cfg_we = 1'b0;
        chk("clr_busy_len", n, 16);
        lookup("post_clr", 1, 16'h0800, 'h110F0);
        lookup("drop_we", 0, 16'h0000, 'h110F0);

        cfg_write(3, 1, 5'h1F, 16'h2000, 16'h1000, 1);
        lookup("start_gt_end", 0, 16'h1800, 'h110F0);
        cfg_write(4, 1, 5'h1F, 16'h1800, 16'h1800, 2);
        lookup("single_code", 4, 16'h1800, 'h104F4);
        lookup("single_miss", 4, 16'h1801, 'h110F0);
        lookup("layer5", 5, 16'h1800, 'h110F0);
        lookup("layer7", 7, 16'h1800, 'h110F0);

        // Reset while a hitting lookup is in flight.
        req(0, 16'h1800);
        tick();
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        chk("rst_flush", seen, 0);
        chk("rst_flush_out", res(), 'h01000);
        rst_n = 1'b1;
        guard = 0;
        while (busy && guard < 40) begin
            tick();
            guard++;
        end
        chk("rst2_ready", bus.req_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
